// File: rtl/cur_fetch.sv
// Current-block fetcher: walks a frame in 8x8 block raster order, loads each
// block's 16 words from frame SRAM into a staging file, then streams them to
// the current-block buffer one word per need_cur cycle.
// Optional build macro CUR_FETCH_UNDERRUN_CHK_EN adds underrun_err/underrun_cnt.
module cur_fetch #(
  parameter int unsigned FRAME_W = 64,
  parameter int unsigned FRAME_H = 64,
  parameter int unsigned ADDR_W  = 16,
  localparam int unsigned NumBx  = FRAME_W / 8,
  localparam int unsigned NumBy  = FRAME_H / 8,
  localparam int unsigned BxW    = (NumBx > 1) ? $clog2(NumBx) : 1,
  localparam int unsigned ByW    = (NumBy > 1) ? $clog2(NumBy) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  input  logic              need_cur,
  output logic [31:0]       cur_in,
  output logic              stage_ready,
  output logic [BxW-1:0]    blk_x,
  output logic [ByW-1:0]    blk_y,
  output logic              busy,
`ifdef CUR_FETCH_UNDERRUN_CHK_EN
  output logic              underrun_err,
  output logic [7:0]        underrun_cnt,
`endif
  output logic              frame_done
);

  typedef enum logic [2:0] {StIdle, StLoad, StCapt, StReady, StSend} state_e;

  state_e         state_q, state_d;
  logic [3:0]     ld_idx_q, ld_idx_d;
  logic [3:0]     rd_idx_q, rd_idx_d;
  logic [BxW-1:0] blk_x_q, blk_x_d;
  logic [ByW-1:0] blk_y_q, blk_y_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [31:0]    stage_q [16];

  logic           last_col, last_row, consume, word_last;
  logic [31:0]    row;
  logic [ADDR_W-1:0] addr_w;

  assign last_col  = (blk_x_q == BxW'(NumBx - 1));
  assign last_row  = (blk_y_q == ByW'(NumBy - 1));
  assign consume   = need_cur && ((state_q == StReady) || (state_q == StSend));
  // Word 0 is always taken from READY, so word 15 can only go out in SEND.
  assign word_last = consume && (state_q == StSend) && (rd_idx_q == 4'd15);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic; start outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  if (ld_idx_q == 4'd15) state_d = StCapt;
      StCapt:  state_d = StReady;
      StReady: if (need_cur) state_d = StSend;
      StSend:  if (word_last) state_d = (last_col && last_row) ? StIdle : StLoad;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next state: load/read indices, block walk, busy and done pulse.
  always_comb begin
    ld_idx_d = ld_idx_q;
    rd_idx_d = rd_idx_q;
    blk_x_d  = blk_x_q;
    blk_y_d  = blk_y_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if ((state_q == StIdle) && start) begin
      ld_idx_d = '0;
      rd_idx_d = '0;
      blk_x_d  = '0;
      blk_y_d  = '0;
      busy_d   = 1'b1;
    end
    if (state_q == StLoad) ld_idx_d = ld_idx_q + 4'd1;  // wraps to 0 after word 15
    if (consume) rd_idx_d = rd_idx_q + 4'd1;             // wraps to 0 after word 15
    if (word_last) begin
      if (last_col) begin
        blk_x_d = '0;
        blk_y_d = last_row ? '0 : blk_y_q + ByW'(1);
      end else begin
        blk_x_d = blk_x_q + BxW'(1);
      end
      if (last_col && last_row) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_idx_q <= '0;
      rd_idx_q <= '0;
      blk_x_q  <= '0;
      blk_y_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ld_idx_q <= ld_idx_d;
      rd_idx_q <= rd_idx_d;
      blk_x_q  <= blk_x_d;
      blk_y_q  <= blk_y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Staging file: read data lags the strobe by one cycle, so word k-1 lands
  // while word k is issued, and word 15 lands in CAPT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) stage_q[i] <= '0;
    end else if ((state_q == StLoad) && (ld_idx_q != 4'd0)) begin
      stage_q[ld_idx_q - 4'd1] <= mem_data;
    end else if (state_q == StCapt) begin
      stage_q[15] <= mem_data;
    end
  end

  // SRAM word address of row i = ld_idx[3:1], half j = ld_idx[0] of the block.
  always_comb begin
    row    = 32'(blk_y_q) * 32'd8 + 32'(ld_idx_q[3:1]);
    addr_w = ADDR_W'((row * 32'(FRAME_W) + 32'(blk_x_q) * 32'd8) / 32'd4 + 32'(ld_idx_q[0]));
  end

  // Outputs; cur_in is zero whenever no block is staged (underrun included).
  always_comb begin
    mem_rd      = (state_q == StLoad);
    mem_addr    = mem_rd ? addr_w : '0;
    stage_ready = (state_q == StReady) || (state_q == StSend);
    cur_in      = stage_ready ? stage_q[rd_idx_q] : '0;
    blk_x       = blk_x_q;
    blk_y       = blk_y_q;
    busy        = busy_q;
    frame_done  = done_q;
  end

`ifdef CUR_FETCH_UNDERRUN_CHK_EN
  logic       underrun;
  logic       ur_err_q, ur_err_d;
  logic [7:0] ur_cnt_q, ur_cnt_d;

  assign underrun = need_cur && ((state_q == StIdle) || (state_q == StLoad) ||
                                 (state_q == StCapt));

  // Sticky flag and saturating count; an underrun in the same cycle as an
  // accepted start is still recorded.
  always_comb begin
    ur_err_d = ur_err_q;
    ur_cnt_d = ur_cnt_q;
    if ((state_q == StIdle) && start) begin
      ur_err_d = 1'b0;
      ur_cnt_d = '0;
    end
    if (underrun) begin
      ur_err_d = 1'b1;
      if (ur_cnt_d != 8'hff) ur_cnt_d = ur_cnt_d + 8'd1;
    end
  end

  // Underrun status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ur_err_q <= 1'b0;
      ur_cnt_q <= '0;
    end else begin
      ur_err_q <= ur_err_d;
      ur_cnt_q <= ur_cnt_d;
    end
  end

  assign underrun_err = ur_err_q;
  assign underrun_cnt = ur_cnt_q;
`endif

endmodule

// File: tb/tb_cur_fetch.sv
// Bench for cur_fetch: SRAM model, address/word scoreboard, underrun model.
module tb_cur_fetch;
  localparam int unsigned FW = 64;
  localparam int unsigned FH = 64;

  logic        clk = 1'b0;
  logic        rst, start, need_cur;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [31:0] mem_data, cur_in;
  logic        stage_ready, busy, frame_done;
  logic [2:0]  blk_x, blk_y;
`ifdef CUR_FETCH_UNDERRUN_CHK_EN
  logic        underrun_err;
  logic [7:0]  underrun_cnt;
`endif

  always #5 clk = ~clk;

  cur_fetch #(.FRAME_W(FW), .FRAME_H(FH), .ADDR_W(16)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .need_cur    (need_cur),
    .cur_in      (cur_in),
    .stage_ready (stage_ready),
    .blk_x       (blk_x),
    .blk_y       (blk_y),
    .busy        (busy),
`ifdef CUR_FETCH_UNDERRUN_CHK_EN
    .underrun_err(underrun_err),
    .underrun_cnt(underrun_cnt),
`endif
    .frame_done  (frame_done)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bx;
    logic [2:0]  by;
  } word_t;

  word_t       word_q[$];
  logic [15:0] addr_q[$];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          n_done   = 0;
  bit          exp_idle = 1'b0;
  bit          m_err    = 1'b0;
  int          m_cnt    = 0;

  function automatic logic [31:0] word_of(input logic [15:0] a);
    return {a ^ 16'hA5C3, a};
  endfunction

  function automatic logic [15:0] exp_addr(input int bx, input int by, input int w);
    int r;
    r = by * 8 + w / 2;
    return 16'(r * int'(FW / 4) + bx * 2 + w % 2);
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // SRAM: one-cycle read latency.
  always @(posedge clk) mem_data <= mem_rd ? word_of(mem_addr) : 32'hDEAD_BEEF;

  task automatic push_frame();
    for (int by = 0; by < int'(FH / 8); by++)
      for (int bx = 0; bx < int'(FW / 8); bx++)
        for (int w = 0; w < 16; w++) begin
          logic [15:0] a;
          a = exp_addr(bx, by, w);
          addr_q.push_back(a);
          word_q.push_back('{word_of(a), 3'(bx), 3'(by)});
        end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_rd) begin
        if (addr_q.size() == 0) check("spurious_rd", 64'(mem_rd), 64'(0));
        else check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
      end
      if (need_cur) begin
        if (stage_ready) begin
          if (word_q.size() == 0) check("spurious_word", 64'(stage_ready), 64'(0));
          else begin
            word_t e;
            e = word_q.pop_front();
            check("cur_in", 64'(cur_in), 64'(e.data));
            check("blk_xy", 64'({blk_x, blk_y}), 64'({e.bx, e.by}));
          end
        end else begin
          check("underrun_cur_in", 64'(cur_in), 64'(0));
        end
      end
      if (frame_done) begin
        n_done++;
        check("done_busy", 64'(busy), 64'(0));
        check("done_words_left", 64'(word_q.size()), 64'(0));
      end
`ifdef CUR_FETCH_UNDERRUN_CHK_EN
      check("ur_err", 64'(underrun_err), 64'(m_err));
      check("ur_cnt", 64'(underrun_cnt), 64'(m_cnt));
      if (start && exp_idle) begin
        m_err = 1'b0;
        m_cnt = 0;
      end
      if (need_cur && !stage_ready) begin
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
`endif
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1;
    push_frame();
    exp_idle = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    exp_idle = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (stage_ready) seen = 1'b1;
    end
    if (!seen) check("ready_timeout", 64'(0), 64'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"}, 64'(mem_rd), 64'(0));
    check({tag, "_addr"}, 64'(mem_addr), 64'(0));
    check({tag, "_cur"}, 64'(cur_in), 64'(0));
    check({tag, "_misc"}, 64'({stage_ready, busy, frame_done, blk_x, blk_y}), 64'(0));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; need_cur = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // First block: address order, capture latency, word 0 presented early.
    do_start();
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c < 16) check("load_rd", 64'(mem_rd), 64'(1));
      if (c == 0) check("addr_w0", 64'(mem_addr), 64'(0));
      if (c == 1) check("addr_w1", 64'(mem_addr), 64'(1));
      if (c == 2) check("addr_w2", 64'(mem_addr), 64'(16));
      if (c == 15) check("addr_w15", 64'(mem_addr), 64'(113));
      if (c == 16) check("capt_rd_ready", 64'({mem_rd, stage_ready}), 64'(0));
      if (c == 17) begin
        check("ready_at_17", 64'(stage_ready), 64'(1));
        check("ready_cur0", 64'(cur_in), 64'(word_of(16'd0)));
        check("ready_busy", 64'(busy), 64'(1));
      end
    end
    @(posedge clk);
    #1 need_cur = 1'b1;
    repeat (16) @(posedge clk);
    #1 need_cur = 1'b0;
    @(negedge clk);
    check("blk1_xy", 64'({blk_x, blk_y}), 64'({3'd1, 3'd0}));
    check("blk1_addr0", 64'(mem_addr), 64'(2));
    check("blk1_ready", 64'(stage_ready), 64'(0));

    // Second block: alternating need_cur.
    wait_ready(40);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1 need_cur = (i % 2 == 0);
    end
    @(negedge clk);
    check("blk2_xy", 64'({blk_x, blk_y}), 64'({3'd2, 3'd0}));

    // Rest of frame: random need_cur with underruns and an ignored start.
    for (int i = 0; i < 20000 && n_done == 0; i++) begin
      @(posedge clk);
      #1;
      need_cur = ($urandom_range(0, 3) != 0);
      start    = (i == 60);
    end
    need_cur = 1'b0;
    start    = 1'b0;
    check("frame_done_seen", 64'(n_done), 64'(1));
    repeat (5) @(negedge clk);
    check("done_once", 64'(n_done), 64'(1));
    check("idle_busy", 64'(busy), 64'(0));
    check("addr_q_empty", 64'(addr_q.size()), 64'(0));
    check("word_q_empty", 64'(word_q.size()), 64'(0));

    // Reset mid-LOAD aborts immediately.
    do_start();
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check_all_zero("abort");
`ifdef CUR_FETCH_UNDERRUN_CHK_EN
    check("abort_ur", 64'({underrun_err, underrun_cnt}), 64'(0));
`endif
    addr_q.delete();
    word_q.delete();
    m_err = 1'b0;
    m_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b1;

    // Restart: block (0,0) again, with a 3-cycle underrun during LOAD.
    do_start();
    need_cur = 1'b1;
    @(negedge clk);
    check("restart_addr0", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'd0}));
    repeat (3) @(posedge clk);
    #1 need_cur = 1'b0;
    @(negedge clk);
`ifdef CUR_FETCH_UNDERRUN_CHK_EN
    check("load_ur_err", 64'(underrun_err), 64'(1));
    check("load_ur_cnt", 64'(underrun_cnt), 64'(3));
`endif
    wait_ready(40);
    @(posedge clk);
    #1 need_cur = 1'b1;
    repeat (16) @(posedge clk);
    #1 need_cur = 1'b0;
    @(negedge clk);
    check("restart_blk1_xy", 64'({blk_x, blk_y}), 64'({3'd1, 3'd0}));
    check("restart_done_cnt", 64'(n_done), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/cur_fetch.md
Name: cur_fetch

Overview:
- Feeder for the current-block ping-pong buffer. Walks a frame in 8x8 block raster order and reads each block's 16 words (4 pixels each) from current-frame SRAM into a staging register file.
- Streams the staged words on cur_in, one word per cycle, while the buffer asserts need_cur.
- Sits between the frame SRAM and the current-block buffer on the current-block path of the ME datapath.

Parameters:
- FRAME_W, 64, frame width in pixels; multiple of 8.
- FRAME_H, 64, frame height in pixels; multiple of 8.
- ADDR_W, 16, SRAM word-address width.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- start  input  1  one-cycle pulse; begin a frame at block (0,0)
- mem_rd  output  1  SRAM read strobe
- mem_addr  output  ADDR_W  SRAM word address
- mem_data  input  32  read data; valid the cycle after mem_rd
- need_cur  input  1  buffer requests one word this cycle
- cur_in  output  32  word to the buffer; bits [7:0] = leftmost pixel
- stage_ready  output  1  staging holds a complete, unsent block
- blk_x  output  clog2(FRAME_W/8)  column of the staged/sending block
- blk_y  output  clog2(FRAME_H/8)  row of the staged/sending block
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse after the last block is fully sent

Behaviour:
- Reset values (asynchronous, active-low): all outputs 0, state IDLE, staging 0, counters 0.
- Word order within a block: word 2i = row i pixels 0..3; word 2i+1 = row i pixels 4..7.
- Address of word 2i+j = ((blk_y*8+i)*FRAME_W + blk_x*8)/4 + j, truncated to ADDR_W.
- FSM states: IDLE, LOAD, CAPT, READY, SEND.
- IDLE
  - start=1 -> LOAD; blk_x=blk_y=0; busy=1.
  - start while not IDLE is ignored.
- LOAD
  - 16 consecutive cycles with mem_rd=1; addresses for words 0..15.
  - mem_data from the previous cycle's read is written into stage[k-1].
  - After issuing word 15 -> CAPT.
- CAPT
  - Capture word 15, then -> READY with stage_ready=1.
  - Read-to-ready latency: 17 cycles after entering LOAD.
- READY
  - cur_in = stage[0].
  - need_cur=1 -> SEND; rd_idx advances to 1 on the same edge.
- SEND
  - cur_in = stage[rd_idx], combinational.
  - rd_idx increments on each cycle need_cur=1; holds when need_cur=0.
  - Edge where word 15 is consumed: stage_ready->0, rd_idx->0, then advance the block:
    - blk_x increments; at FRAME_W/8-1 it wraps to 0 and blk_y increments.
    - If the block just sent was the last one (blk_x=FRAME_W/8-1, blk_y=FRAME_H/8-1): frame_done pulses next cycle, busy->0, -> IDLE.
    - Otherwise -> LOAD.
- need_cur=1 in IDLE, LOAD or CAPT: underrun. cur_in=0, no index advance, no state change.
- mem_rd is never asserted outside LOAD.
- Reset mid-frame aborts immediately; no frame_done.

Optional Feature:
- Macro: CUR_FETCH_UNDERRUN_CHK_EN.
- Defined:
  - Adds output underrun_err (1 bit, reset 0).
  - Sticky; set the cycle after any underrun.
  - Cleared only by reset or by start accepted in IDLE.
  - Adds output underrun_cnt (8 bits, saturating at 255), counting underrun cycles.
- Undefined: neither port exists. Underrun behaves as in Behaviour, silently.

Test Plan:
- Reset then start, FRAME_W=64: mem_addr sequence 0,1,16,17,...,112,113 over 16 cycles; stage_ready=1 at cycle 17; cur_in=stage[0] before need_cur.
- need_cur held high 16 cycles -> cur_in equals SRAM words in order; the second block's first read address is 2; blk_x=1, blk_y=0.
- need_cur toggled 1,0,1,0 during SEND -> cur_in advances only on need_cur=1 cycles; no skipped or repeated word.
- Full 64x64 frame: 64 blocks delivered; frame_done pulses once after block (7,7); busy->0; a start pulse mid-frame has no effect.
- need_cur=1 during LOAD -> cur_in=0; with CUR_FETCH_UNDERRUN_CHK_EN, underrun_err=1 and underrun_cnt matches the number of underrun cycles.
- rst asserted mid-LOAD -> all outputs 0 immediately, mem_rd=0; a new start fetches block (0,0).
